mul_share_arbiter: RTL and testbench

Sequencing controller that shares one `MultiplierNbit` datapath instance between `REQ` independent requesters. It accepts operand pairs over a valid/ready handshake and grants the multiplier round-robin. It holds the registered operands stable for a programmable settle window, captures the product and returns it with the requester ID over a second valid/ready handshake. It sits between the requesters (button/switch front-ends, test sequencers) and the single multiplier that feeds the seven-segment display path.

---
 rtl/mul_share_arbiter_pkg.sv | 38 +++
 rtl/mul_share_arbiter_if.sv | 28 ++
 rtl/mul_share_arbiter_rr_arbiter.sv | 30 +++
 rtl/mul_share_arbiter.sv | 110 +++++++++++
 tb/tb_mul_share_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter: FSM states,
// parameter limits and the round-robin scan function.
package mul_pkg;

  localparam int unsigned MAX_REQ    = 4;
  localparam int unsigned MAX_SETTLE = 15;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // Scan from ptr upward, wrapping at nreq; the first set bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PTR_W-1:0]   ptr,
                                       input int unsigned        nreq);
    rr_pick_t         r;
    logic [PTR_W-1:0] i;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      i = PTR_W'((32'(ptr) + k) % nreq);
      if (k < nreq && !r.found && valid[i]) begin
        r.found = 1'b1;
        r.idx   = i;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester and result handshake bundle between the front-ends and the
// multiplier-sharing arbiter.
interface mul_share_arbiter_if #(
  parameter int unsigned N   = 5,
  parameter int unsigned REQ = 2,
  parameter int unsigned IDW = 2
) ();

  logic [REQ-1:0]   req_valid;
  logic [REQ*N-1:0] req_m;
  logic [REQ*N-1:0] req_q;
  logic [REQ-1:0]   req_ready;
  logic             res_valid;
  logic [2*N-1:0]   res_p;
  logic [IDW-1:0]   res_id;
  logic             res_ready;

  modport master (
    output req_valid, req_m, req_q, res_ready,
    input  req_ready, res_valid, res_p, res_id
  );

  modport slave (
    input  req_valid, req_m, req_q, res_ready,
    output req_ready, res_valid, res_p, res_id
  );

endinterface

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus encoded winner index,
// starting the search at ptr.
module rr_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned REQ = 2
) (
  input  logic [REQ-1:0]   req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ-1:0]   grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [MAX_REQ-1:0] valid_ext;
  rr_pick_t           pick;

  always_comb begin
    valid_ext            = '0;
    valid_ext[REQ-1:0]   = req_valid;
    pick                 = rr_pick(valid_ext, ptr, REQ);
    found                = pick.found;
    idx                  = pick.idx;
    grant                = '0;
    for (int i = 0; i < REQ; i++) begin
      grant[i] = pick.found && (pick.idx == PTR_W'(i));
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external multiplier between REQ requesters: round-robin grant,
// operands held for SETTLE cycles, product returned with the owner's ID.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int unsigned N      = 5,
  parameter int unsigned REQ    = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned IDW    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_share_arbiter_if.slave  bus,
  output logic [N-1:0]        mul_m,
  output logic [N-1:0]        mul_q,
  input  logic [2*N-1:0]      mul_p,
  output logic                busy
);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, win_idx;
  logic [REQ-1:0]   grant;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     sel_m, sel_q;

  rr_arbiter #(.REQ(REQ)) u_rr (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .idx       (win_idx),
    .found     (found)
  );

  always_comb begin
    sel_m = '0;
    sel_q = '0;
    for (int i = 0; i < REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_m = bus.req_m[i*N +: N];
        sel_q = bus.req_q[i*N +: N];
      end
    end
  end

  // The pointer advances past the owner, whose index is already in res_id.
  always_comb begin
    ptr_nxt = '0;
    if (32'(bus.res_id) + 1 < REQ) ptr_nxt = PTR_W'(32'(bus.res_id) + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so it reads zero while reset is held.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (found && rst_n) begin
          bus.req_ready = grant;
          state_nxt     = CALC;
        end
      end
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      cnt           <= '0;
      mul_m         <= '0;
      mul_q         <= '0;
      bus.res_p     <= '0;
      bus.res_id    <= '0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            mul_m      <= sel_m;
            mul_q      <= sel_q;
            bus.res_id <= IDW'(win_idx);
            cnt        <= CNT_W'(SETTLE - 1);
          end
        end
        CALC: begin
          if (cnt == '0) begin
            bus.res_p     <= mul_p;
            bus.res_valid <= 1'b1;
            ptr           <= ptr_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (bus.res_ready) bus.res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: cycle model checks a SETTLE=1 instance every
// cycle; directed literal checks pin single, backpressure, reset, fairness, settle.
module tb_mul_share_arbiter;

  localparam int unsigned N   = 5;
  localparam int unsigned REQ = 2;
  localparam int unsigned IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N(N), .REQ(REQ), .IDW(IDW)) bus_a ();
  mul_share_arbiter_if #(.N(N), .REQ(REQ), .IDW(IDW)) bus_b ();

  logic [N-1:0]   mul_m_a, mul_q_a, mul_m_b, mul_q_b;
  logic [2*N-1:0] mul_p_a, mul_p_b;
  logic           busy_a, busy_b;

  assign mul_p_a = (2*N)'(mul_m_a) * (2*N)'(mul_q_a);
  assign mul_p_b = (2*N)'(mul_m_b) * (2*N)'(mul_q_b);

  mul_share_arbiter #(.N(N), .REQ(REQ), .SETTLE(1), .IDW(IDW)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .mul_m(mul_m_a), .mul_q(mul_q_a), .mul_p(mul_p_a), .busy(busy_a)
  );

  mul_share_arbiter #(.N(N), .REQ(REQ), .SETTLE(4), .IDW(IDW)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .mul_m(mul_m_b), .mul_q(mul_q_b), .mul_p(mul_p_b), .busy(busy_b)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int p, input logic [REQ-1:0] v);
    for (int k = 0; k < int'(REQ); k++) begin
      if (v[(p + k) % REQ]) return (p + k) % REQ;
    end
    return -1;
  endfunction

  // Job-level model of instance a: a job is granted, needs SETTLE edges,
  // then its product is held until accepted.
  bit md_act, md_hold;
  int md_wait, md_ptr, md_id, md_m, md_q, md_res;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      md_act <= 0; md_hold <= 0; md_wait <= 0; md_ptr <= 0;
      md_id <= 0; md_m <= 0; md_q <= 0; md_res <= 0;
    end else if (md_hold) begin
      if (bus_a.res_ready) md_hold <= 0;
    end else if (md_act) begin
      md_wait <= md_wait - 1;
      if (md_wait == 1) begin
        md_act  <= 0;
        md_hold <= 1;
        md_res  <= md_m * md_q;
        md_ptr  <= (md_id + 1) % REQ;
      end
    end else begin
      w = pick(md_ptr, bus_a.req_valid);
      if (w >= 0) begin
        md_act  <= 1;
        md_wait <= 1;
        md_id   <= w;
        md_m    <= int'(bus_a.req_m[w*N +: N]);
        md_q    <= int'(bus_a.req_q[w*N +: N]);
      end
    end
  end

  always @(negedge clk) begin
    int w;
    logic [REQ-1:0] er;
    if (cmp_en) begin
      er = '0;
      if (rst_n && !md_act && !md_hold) begin
        w = pick(md_ptr, bus_a.req_valid);
        if (w >= 0) er[w] = 1'b1;
      end
      chk("m_req_ready", 32'(bus_a.req_ready), 32'(er));
      chk("m_busy",      32'(busy_a),          32'(md_act || md_hold));
      chk("m_res_valid", 32'(bus_a.res_valid), 32'(md_hold));
      chk("m_res_p",     32'(bus_a.res_p),     md_res);
      chk("m_res_id",    32'(bus_a.res_id),    md_id);
      chk("m_mul_m",     32'(mul_m_a),         md_m);
      chk("m_mul_q",     32'(mul_q_a),         md_q);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int res_p_q[$];
  int res_id_q[$];
  int k;

  initial begin
    bus_a.req_valid = '0; bus_a.req_m = '0; bus_a.req_q = '0; bus_a.res_ready = 1'b0;
    bus_b.req_valid = '0; bus_b.req_m = '0; bus_b.req_q = '0; bus_b.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus_a.req_ready), 0);
    chk("rst_res_valid", 32'(bus_a.res_valid), 0);
    chk("rst_busy",      32'(busy_a),          0);
    chk("rst_mul_m",     32'(mul_m_a),         0);
    chk("rst_res_id",    32'(bus_a.res_id),    0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single request 31*31, then held under backpressure
    bus_a.req_m = {5'd0, 5'd31}; bus_a.req_q = {5'd0, 5'd31}; bus_a.req_valid = 2'b01;
    #1 chk("single_ready", 32'(bus_a.req_ready), 1);
    tick();
    bus_a.req_valid = 2'b00;
    #1 chk("single_busy", 32'(busy_a), 1);
    chk("single_ready_low", 32'(bus_a.req_ready), 0);
    tick();
    chk("single_valid", 32'(bus_a.res_valid), 1);
    chk("single_p",     32'(bus_a.res_p),     961);
    chk("single_id",    32'(bus_a.res_id),    0);

    bus_a.req_m = {5'd0, 5'd0}; bus_a.req_q = {5'd0, 5'd25}; bus_a.req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_p",     32'(bus_a.res_p),     961);
      chk("bp_id",    32'(bus_a.res_id),    0);
      chk("bp_ready", 32'(bus_a.req_ready), 0);
      chk("bp_busy",  32'(busy_a),          1);
    end
    bus_a.res_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus_a.res_valid), 0);
    chk("bp_next_grant",    32'(bus_a.req_ready), 1);

    // Zero operand
    tick();
    bus_a.req_valid = 2'b00;
    tick();
    chk("zero_valid", 32'(bus_a.res_valid), 1);
    chk("zero_p",     32'(bus_a.res_p),     0);
    tick();
    chk("zero_accepted", 32'(bus_a.res_valid), 0);
    bus_a.res_ready = 1'b0;

    // Reset in CALC: requester 1 granted (pointer sits at 1), then discarded
    bus_a.req_m = {5'd2, 5'd0}; bus_a.req_q = {5'd3, 5'd0}; bus_a.req_valid = 2'b10;
    #1 chk("rm_grant", 32'(bus_a.req_ready), 2);
    tick();
    bus_a.req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rm_busy",  32'(busy_a),          0);
    chk("rm_valid", 32'(bus_a.res_valid), 0);
    chk("rm_mul_m", 32'(mul_m_a),         0);
    chk("rm_mul_q", 32'(mul_q_a),         0);
    chk("rm_id",    32'(bus_a.res_id),    0);
    chk("rm_p",     32'(bus_a.res_p),     0);
    repeat (2) tick();
    chk("rm_no_result", 32'(bus_a.res_valid), 0);
    rst_n = 1'b1;
    tick();

    // Contention: both valid, results must alternate starting at requester 0
    bus_a.req_m = {5'd5, 5'd3}; bus_a.req_q = {5'd6, 5'd4};
    bus_a.req_valid = 2'b11; bus_a.res_ready = 1'b1;
    #1 chk("rr_first_grant", 32'(bus_a.req_ready), 1);
    k = 0;
    while (res_p_q.size() < 3 && k < 40) begin
      tick();
      k++;
      if (bus_a.res_valid) begin
        res_p_q.push_back(int'(bus_a.res_p));
        res_id_q.push_back(int'(bus_a.res_id));
      end
    end
    chk("rr_count", res_p_q.size(), 3);
    if (res_p_q.size() == 3) begin
      chk("rr_p0",  res_p_q[0],  12); chk("rr_id0", res_id_q[0], 0);
      chk("rr_p1",  res_p_q[1],  30); chk("rr_id1", res_id_q[1], 1);
      chk("rr_p2",  res_p_q[2],  12); chk("rr_id2", res_id_q[2], 0);
    end
    bus_a.req_valid = 2'b00;
    repeat (4) tick();

    // Settle window on the SETTLE=4 instance
    bus_b.req_m = {5'd0, 5'd7}; bus_b.req_q = {5'd0, 5'd9}; bus_b.req_valid = 2'b01;
    #1 chk("s4_grant", 32'(bus_b.req_ready), 1);
    tick();
    bus_b.req_valid = 2'b00;
    k = 0;
    while (!bus_b.res_valid && k < 12) begin
      chk("s4_mul_m", 32'(mul_m_b), 7);
      chk("s4_mul_q", 32'(mul_q_b), 9);
      tick();
      k++;
    end
    chk("s4_edges", k, 4);
    chk("s4_p",     32'(bus_b.res_p),  63);
    chk("s4_id",    32'(bus_b.res_id), 0);
    chk("s4_busy",  32'(busy_b),       1);
    bus_b.res_ready = 1'b1;
    tick();
    chk("s4_accepted", 32'(bus_b.res_valid), 0);
    chk("s4_hold_m",   32'(mul_m_b),         7);
    bus_b.res_ready = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
